// File: rtl/difftest_vecwb_pkg.sv
// Shared types, widths and helpers for the difftest vector-writeback collector.
// Optional feature macro used by the collector: DIFFTEST_VECWB_DEDUP_EN.
package difftest_vecwb_pkg;

    localparam int VLEN     = 128;
    localparam int ADDR_W   = 7;
    localparam int COREID_W = 8;
    localparam int ENTRY_W  = ADDR_W + VLEN + COREID_W;
    localparam int DROP_W   = 16;

    typedef struct packed {
        logic [ADDR_W-1:0]   addr;
        logic [VLEN-1:0]     data;
        logic [COREID_W-1:0] coreid;
    } vecwb_entry_t;

    function automatic logic [DROP_W-1:0] sat_add_drop(
        input logic [DROP_W-1:0] a,
        input logic [DROP_W-1:0] b
    );
        logic [DROP_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[DROP_W]) begin
            return {DROP_W{1'b1}};
        end else begin
            return sum[DROP_W-1:0];
        end
    endfunction

endpackage

// File: rtl/difftest_vecwb_fifo.sv
// Multi-push, single-pop circular event buffer. Takes a compacted push vector
// plus a push count and reports how many of those pushes it accepted.
module difftest_vecwb_fifo
    import difftest_vecwb_pkg::*;
#(
    parameter int NPORTS = 4,
    parameter int DEPTH  = 16,
    localparam int PCNT_W = $clog2(NPORTS + 1),
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NPORTS*ENTRY_W-1:0] i_push_flat,
    input  logic [PCNT_W-1:0]         i_push_cnt,
    input  logic                      i_pop,
    output logic [PCNT_W-1:0]         o_acc_cnt,
    output logic [ENTRY_W-1:0]        o_head,
    output logic [CNT_W-1:0]          o_count
);

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_free;
    logic [CNT_W-1:0]   w_push_ext;
    logic [CNT_W-1:0]   w_acc_ext;

    // Free slots include the one released by a pop on the same edge.
    always_comb begin
        w_free     = CNT_W'(DEPTH) - r_count + CNT_W'(i_pop);
        w_push_ext = CNT_W'(i_push_cnt);
        if (w_push_ext > w_free) begin
            w_acc_ext = w_free;
        end else begin
            w_acc_ext = w_push_ext;
        end
    end

    assign o_acc_cnt = PCNT_W'(w_acc_ext);

    // Accepted pushes land in consecutive slots from the write pointer.
    always_ff @(posedge clock) begin
        for (int j = 0; j < NPORTS; j++) begin
            if (PCNT_W'(j) < o_acc_cnt) begin
                r_mem[r_wr_ptr + PTR_W'(j)] <= i_push_flat[j*ENTRY_W +: ENTRY_W];
            end
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_acc_ext);
            r_rd_ptr <= r_rd_ptr + PTR_W'(i_pop);
            r_count  <= r_count + w_acc_ext - CNT_W'(i_pop);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/difftest_vec_wb_collector.sv
// Producer side of the difftest vector-writeback channel: compacts per-port
// writebacks into an in-order queue and drains one event per cycle.
// Optional macro DIFFTEST_VECWB_DEDUP_EN keeps only the highest port per address.
module difftest_vec_wb_collector
    import difftest_vecwb_pkg::*;
#(
    parameter int NPORTS = 4,
    parameter int DEPTH  = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [7:0]               io_coreid,
    input  logic [NPORTS-1:0]        wb_valid,
    input  logic [NPORTS*ADDR_W-1:0] wb_addr,
    input  logic [NPORTS*VLEN-1:0]   wb_data,
    output logic                     out_enable,
    output logic                     out_valid,
    output logic [ADDR_W-1:0]        out_address,
    output logic [63:0]              out_data_0,
    output logic [63:0]              out_data_1,
    output logic [7:0]               out_coreid,
    output logic                     stall,
    output logic                     overflow,
    output logic [15:0]              drop_cnt
);

    localparam int PCNT_W = $clog2(NPORTS + 1);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int FLAT_W = NPORTS * ENTRY_W;

    vecwb_entry_t          w_entry [NPORTS];
    logic [NPORTS-1:0]     w_keep;
    logic [FLAT_W-1:0]     w_push_flat;
    logic [PCNT_W-1:0]     w_push_cnt;
    logic [PCNT_W-1:0]     w_acc_cnt;
    logic [PCNT_W-1:0]     w_drop;
    logic [ENTRY_W-1:0]    w_head;
    vecwb_entry_t          w_head_e;
    logic [CNT_W-1:0]      w_count;
    logic                  w_pop;

    logic                  r_out_en;
    logic [ADDR_W-1:0]     r_out_addr;
    logic [VLEN-1:0]       r_out_data;
    logic [7:0]            r_out_coreid;
    logic                  r_overflow;
    logic [DROP_W-1:0]     r_drop_cnt;

    for (genvar g = 0; g < NPORTS; g++) begin : g_entry
        assign w_entry[g] = {wb_addr[g*ADDR_W +: ADDR_W], wb_data[g*VLEN +: VLEN], io_coreid};
    end

    // Select which valid ports are enqueued this cycle.
    always_comb begin
        w_keep = wb_valid;
`ifdef DIFFTEST_VECWB_DEDUP_EN
        for (int k = 0; k < NPORTS; k++) begin
            for (int j = k + 1; j < NPORTS; j++) begin
                if (wb_valid[k] && wb_valid[j] && (w_entry[k].addr == w_entry[j].addr)) begin
                    w_keep[k] = 1'b0;
                end else begin
                    w_keep[k] = w_keep[k];
                end
            end
        end
`endif
    end

    // Pack kept ports into consecutive slots, lowest port first.
    always_comb begin
        w_push_flat = {FLAT_W{1'b0}};
        w_push_cnt  = {PCNT_W{1'b0}};
        for (int k = 0; k < NPORTS; k++) begin
            if (w_keep[k]) begin
                w_push_flat = w_push_flat | (FLAT_W'(w_entry[k]) << (w_push_cnt * ENTRY_W));
                w_push_cnt  = w_push_cnt + PCNT_W'(1'b1);
            end else begin
                w_push_cnt  = w_push_cnt;
            end
        end
    end

    assign w_pop = (w_count != {CNT_W{1'b0}});

    difftest_vecwb_fifo #(
        .NPORTS (NPORTS),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .i_push_flat (w_push_flat),
        .i_push_cnt  (w_push_cnt),
        .i_pop       (w_pop),
        .o_acc_cnt   (w_acc_cnt),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    assign w_head_e = w_head;
    assign w_drop   = w_push_cnt - w_acc_cnt;

    // Output event register and sticky drop status.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_en     <= 1'b0;
            r_out_addr   <= {ADDR_W{1'b0}};
            r_out_data   <= {VLEN{1'b0}};
            r_out_coreid <= 8'h00;
            r_overflow   <= 1'b0;
            r_drop_cnt   <= {DROP_W{1'b0}};
        end else begin
            if (w_pop) begin
                r_out_en     <= 1'b1;
                r_out_addr   <= w_head_e.addr;
                r_out_data   <= w_head_e.data;
                r_out_coreid <= w_head_e.coreid;
            end else begin
                r_out_en     <= 1'b0;
            end
            if (w_drop != {PCNT_W{1'b0}}) begin
                r_overflow <= 1'b1;
                r_drop_cnt <= sat_add_drop(r_drop_cnt, DROP_W'(w_drop));
            end
        end
    end

    assign out_enable  = r_out_en;
    assign out_valid   = r_out_en;
    assign out_address = r_out_addr;
    assign out_data_0  = r_out_data[63:0];
    assign out_data_1  = r_out_data[127:64];
    assign out_coreid  = r_out_coreid;
    assign overflow    = r_overflow;
    assign drop_cnt    = r_drop_cnt;
    assign stall       = (CNT_W'(DEPTH) - w_count) < CNT_W'(NPORTS);

endmodule

// File: tb/tb_difftest_vec_wb_collector.sv
// Directed, table-driven bench for difftest_vec_wb_collector (NPORTS=4, DEPTH=16).
module tb_difftest_vec_wb_collector;

    logic           clock = 1'b0;
    logic           reset;
    logic [7:0]     io_coreid;
    logic [3:0]     wb_valid;
    logic [27:0]    wb_addr;
    logic [511:0]   wb_data;
    logic           out_enable;
    logic           out_valid;
    logic [6:0]     out_address;
    logic [63:0]    out_data_0;
    logic [63:0]    out_data_1;
    logic [7:0]     out_coreid;
    logic           stall;
    logic           overflow;
    logic [15:0]    drop_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    difftest_vec_wb_collector #(.NPORTS(4), .DEPTH(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .io_coreid   (io_coreid),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .out_enable  (out_enable),
        .out_valid   (out_valid),
        .out_address (out_address),
        .out_data_0  (out_data_0),
        .out_data_1  (out_data_1),
        .out_coreid  (out_coreid),
        .stall       (stall),
        .overflow    (overflow),
        .drop_cnt    (drop_cnt)
    );

    typedef struct {
        logic            rst;
        logic [3:0]      valid;
        logic [3:0][6:0] addr;
        logic            en;
        logic [6:0]      eaddr;
        logic            estall;
        logic            eovf;
        logic [15:0]     edrop;
    } vec_t;

    vec_t vecs [24];

    function automatic logic [127:0] mk_data(input logic [6:0] a);
        mk_data = {64'hC0DE_0000_0000_0000 | {57'd0, a}, 64'h0000_0000_BEEF_0000 | {57'd0, a}};
    endfunction

    function automatic vec_t mkv(input logic r, input logic [3:0] v,
                                 input logic [6:0] a0, input logic [6:0] a1,
                                 input logic [6:0] a2, input logic [6:0] a3,
                                 input logic e, input logic [6:0] ea,
                                 input logic es, input logic eo, input logic [15:0] ed);
        vec_t t;
        t.rst = r; t.valid = v; t.addr = {a3, a2, a1, a0};
        t.en = e; t.eaddr = ea; t.estall = es; t.eovf = eo; t.edrop = ed;
        return t;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] v, input logic [3:0][6:0] a);
        reset    = r;
        wb_valid = v;
        for (int k = 0; k < 4; k++) begin
            wb_addr[k*7 +: 7]     = a[k];
            wb_data[k*128 +: 128] = mk_data(a[k]);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; io_coreid = 8'h3C; wb_valid = 4'h0; wb_addr = 28'd0; wb_data = 512'd0;

        //            rst  valid  a0     a1     a2     a3     en    eaddr  stall ovf   drop
        vecs[0]  = mkv(1'b1, 4'h0, 7'd0,  7'd0,  7'd0,  7'd0,  1'b0, 7'd0,  1'b0, 1'b0, 16'd0);
        vecs[1]  = mkv(1'b0, 4'h0, 7'd0,  7'd0,  7'd0,  7'd0,  1'b0, 7'd0,  1'b0, 1'b0, 16'd0);
        vecs[2]  = mkv(1'b0, 4'hF, 7'd1,  7'd2,  7'd3,  7'd4,  1'b0, 7'd0,  1'b0, 1'b0, 16'd0);
        vecs[3]  = mkv(1'b0, 4'h0, 7'd0,  7'd0,  7'd0,  7'd0,  1'b1, 7'd1,  1'b0, 1'b0, 16'd0);
        vecs[4]  = mkv(1'b0, 4'h0, 7'd0,  7'd0,  7'd0,  7'd0,  1'b1, 7'd2,  1'b0, 1'b0, 16'd0);
        vecs[5]  = mkv(1'b0, 4'h0, 7'd0,  7'd0,  7'd0,  7'd0,  1'b1, 7'd3,  1'b0, 1'b0, 16'd0);
        vecs[6]  = mkv(1'b0, 4'h0, 7'd0,  7'd0,  7'd0,  7'd0,  1'b1, 7'd4,  1'b0, 1'b0, 16'd0);
        vecs[7]  = mkv(1'b0, 4'h0, 7'd0,  7'd0,  7'd0,  7'd0,  1'b0, 7'd4,  1'b0, 1'b0, 16'd0);
        vecs[8]  = mkv(1'b0, 4'hF, 7'd10, 7'd11, 7'd12, 7'd13, 1'b0, 7'd4,  1'b0, 1'b0, 16'd0);
        vecs[9]  = mkv(1'b0, 4'hF, 7'd14, 7'd15, 7'd16, 7'd17, 1'b1, 7'd10, 1'b0, 1'b0, 16'd0);
        vecs[10] = mkv(1'b0, 4'hF, 7'd18, 7'd19, 7'd20, 7'd21, 1'b1, 7'd11, 1'b0, 1'b0, 16'd0);
        vecs[11] = mkv(1'b0, 4'hF, 7'd22, 7'd23, 7'd24, 7'd25, 1'b1, 7'd12, 1'b1, 1'b0, 16'd0);
        vecs[12] = mkv(1'b0, 4'hF, 7'd26, 7'd27, 7'd28, 7'd29, 1'b1, 7'd13, 1'b1, 1'b0, 16'd0);
        vecs[13] = mkv(1'b0, 4'hF, 7'd30, 7'd31, 7'd32, 7'd33, 1'b1, 7'd14, 1'b1, 1'b1, 16'd3);
        vecs[14] = mkv(1'b0, 4'h0, 7'd0,  7'd0,  7'd0,  7'd0,  1'b1, 7'd15, 1'b1, 1'b1, 16'd3);
        vecs[15] = mkv(1'b0, 4'h0, 7'd0,  7'd0,  7'd0,  7'd0,  1'b1, 7'd16, 1'b1, 1'b1, 16'd3);
        vecs[16] = mkv(1'b0, 4'h0, 7'd0,  7'd0,  7'd0,  7'd0,  1'b1, 7'd17, 1'b1, 1'b1, 16'd3);
        vecs[17] = mkv(1'b0, 4'h0, 7'd0,  7'd0,  7'd0,  7'd0,  1'b1, 7'd18, 1'b0, 1'b1, 16'd3);
        vecs[18] = mkv(1'b0, 4'h0, 7'd0,  7'd0,  7'd0,  7'd0,  1'b1, 7'd19, 1'b0, 1'b1, 16'd3);
        vecs[19] = mkv(1'b0, 4'h0, 7'd0,  7'd0,  7'd0,  7'd0,  1'b1, 7'd20, 1'b0, 1'b1, 16'd3);
        vecs[20] = mkv(1'b1, 4'h0, 7'd0,  7'd0,  7'd0,  7'd0,  1'b0, 7'd0,  1'b0, 1'b0, 16'd0);
        vecs[21] = mkv(1'b0, 4'h1, 7'd40, 7'd0,  7'd0,  7'd0,  1'b0, 7'd0,  1'b0, 1'b0, 16'd0);
        vecs[22] = mkv(1'b0, 4'h0, 7'd0,  7'd0,  7'd0,  7'd0,  1'b1, 7'd40, 1'b0, 1'b0, 16'd0);
        vecs[23] = mkv(1'b0, 4'h0, 7'd0,  7'd0,  7'd0,  7'd0,  1'b0, 7'd40, 1'b0, 1'b0, 16'd0);

        for (int i = 0; i < 24; i++) begin
            drive(vecs[i].rst, vecs[i].valid, vecs[i].addr);
            step();
            chk($sformatf("v%0d.enable", i), {127'd0, out_enable}, {127'd0, vecs[i].en});
            chk($sformatf("v%0d.valid", i), {127'd0, out_valid}, {127'd0, vecs[i].en});
            chk($sformatf("v%0d.address", i), {121'd0, out_address}, {121'd0, vecs[i].eaddr});
            chk($sformatf("v%0d.stall", i), {127'd0, stall}, {127'd0, vecs[i].estall});
            chk($sformatf("v%0d.overflow", i), {127'd0, overflow}, {127'd0, vecs[i].eovf});
            chk($sformatf("v%0d.drop_cnt", i), {112'd0, drop_cnt}, {112'd0, vecs[i].edrop});
            if (vecs[i].en) begin
                chk($sformatf("v%0d.data", i), {out_data_1, out_data_0}, mk_data(vecs[i].eaddr));
                chk($sformatf("v%0d.coreid", i), {120'd0, out_coreid}, {120'd0, 8'h3C});
            end
        end

        // Single push with explicit data and a different core id.
        drive(1'b1, 4'h0, 28'd0);
        step();
        drive(1'b0, 4'h1, {7'd0, 7'd0, 7'd0, 7'd5});
        io_coreid = 8'h07;
        wb_data[127:0] = {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222};
        step();
        chk("single.latency_en", {127'd0, out_enable}, 128'd0);
        wb_valid = 4'h0;
        step();
        chk("single.en", {127'd0, out_enable}, 128'd1);
        chk("single.addr", {121'd0, out_address}, 128'd5);
        chk("single.data_1", {64'd0, out_data_1}, {64'd0, 64'h1111_1111_1111_1111});
        chk("single.data_0", {64'd0, out_data_0}, {64'd0, 64'h2222_2222_2222_2222});
        chk("single.coreid", {120'd0, out_coreid}, 128'h07);
        step();
        chk("single.after_en", {127'd0, out_enable}, 128'd0);
        chk("single.hold_data_0", {64'd0, out_data_0}, {64'd0, 64'h2222_2222_2222_2222});

        // Ports 0 and 2 hit the same register in one cycle.
        drive(1'b1, 4'h0, 28'd0);
        step();
        drive(1'b0, 4'h5, {7'd0, 7'd9, 7'd0, 7'd9});
        wb_data[127:0]   = {64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_0000_0000_000A};
        wb_data[383:256] = {64'hBBBB_BBBB_BBBB_BBBB, 64'hBBBB_0000_0000_000B};
        step();
        wb_valid = 4'h0;
        step();
        chk("dup.first_en", {127'd0, out_enable}, 128'd1);
        chk("dup.first_addr", {121'd0, out_address}, 128'd9);
`ifdef DIFFTEST_VECWB_DEDUP_EN
        chk("dup.first_data", {64'd0, out_data_0}, {64'd0, 64'hBBBB_0000_0000_000B});
        step();
        chk("dup.second_en", {127'd0, out_enable}, 128'd0);
`else
        chk("dup.first_data", {64'd0, out_data_0}, {64'd0, 64'hAAAA_0000_0000_000A});
        step();
        chk("dup.second_en", {127'd0, out_enable}, 128'd1);
        chk("dup.second_data", {64'd0, out_data_0}, {64'd0, 64'hBBBB_0000_0000_000B});
`endif
        chk("dup.no_drop", {112'd0, drop_cnt}, 128'd0);

        // Drive the queue full, then drop 3 per cycle until drop_cnt saturates.
        drive(1'b1, 4'h0, 28'd0);
        step();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 4'hF, {7'd4, 7'd3, 7'd2, 7'd1});
            step();
        end
        chk("sat.fill_drop", {112'd0, drop_cnt}, 128'd0);
        chk("sat.fill_stall", {127'd0, stall}, 128'd1);
        for (int i = 1; i <= 21846; i++) begin
            step();
            if (i == 21844) chk("sat.near", {112'd0, drop_cnt}, 128'd65532);
            if (i == 21845) chk("sat.reach", {112'd0, drop_cnt}, 128'hFFFF);
        end
        chk("sat.hold", {112'd0, drop_cnt}, 128'hFFFF);
        chk("sat.overflow", {127'd0, overflow}, 128'd1);
        drive(1'b1, 4'h0, 28'd0);
        step();
        chk("sat.reset_drop", {112'd0, drop_cnt}, 128'd0);
        chk("sat.reset_stall", {127'd0, stall}, 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/difftest_vec_wb_collector.md
# difftest_vec_wb_collector

Producer side of the difftest vector-writeback channel. Samples up to NPORTS vector-register writebacks per cycle from the core's vector writeback stage and queues them in order. Drains one 128-bit event per cycle into the DifftestVecWriteback DPI sink. Raises a stall hint before the queue can overflow, and keeps sticky overflow status for the harness.

## Interface
Parameters:
- NPORTS, 4: number of vector writeback ports sampled per cycle (1..8).
- DEPTH, 16: event queue entries; power of two, and DEPTH ≥ 2*NPORTS.

Ports:
- clock  in  1  single clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- io_coreid  in  8  core id, forwarded with every event.
- wb_valid  in  NPORTS  per-port writeback valid.
- wb_addr  in  NPORTS*7  per-port vector register index; port k at bits [7k+6:7k].
- wb_data  in  NPORTS*128  per-port data; port k at bits [128k+127:128k].
- out_enable  out  1  event present this cycle (drives sink enable).
- out_valid  out  1  equal to out_enable.
- out_address  out  7  event register index.
- out_data_0  out  64  data bits [63:0].
- out_data_1  out  64  data bits [127:64].
- out_coreid  out  8  io_coreid sampled with the event.
- stall  out  1  free entries < NPORTS; the core must hold writebacks off next cycle.
- overflow  out  1  sticky; set when any valid writeback was dropped.
- drop_cnt  out  16  saturating count of dropped writebacks.

## Operation
- Push: each cycle, valid ports are enqueued in ascending port index. Entry = {addr, data, coreid}.
- Free space for this cycle = DEPTH − count + (1 if a pop occurs this cycle).
- If the valid pushes exceed free space, the lowest-index pushes that fit are kept. The remainder are dropped, overflow is set, and drop_cnt adds the number dropped, saturating at 0xFFFF.
- Pop: whenever count > 0, the head is registered to the out_* outputs and removed. Throughput is 1 event per cycle.
- When count = 0, out_enable = out_valid = 0. out_address and out_data hold their last values.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH, with width log2(DEPTH)+1.
- stall is combinational from the registered count: stall = (DEPTH − count) < NPORTS.
- Reset, applied in any cycle including mid-drain:
  - count, pointers, overflow and drop_cnt go to 0.
  - All out_* go to 0; stall goes to 0.
  - Queued events are discarded, and no event is emitted in the cycle after reset.

## Timing
- A writeback sampled at edge N with an empty queue appears on out_* during cycle N+1.
- The j-th valid port in a cycle (j from 0) appears at N+1+j, plus the number of entries already queued ahead of it.
- Push and pop in the same cycle are legal at any fill level, including full.
- stall reflects count after edge N and is valid throughout cycle N.

## Configuration
- DIFFTEST_VECWB_DEDUP_EN defined: when several ports write the same address in one cycle, only the highest-index such port is enqueued. The lower-index duplicates are discarded silently and do not count as drops.
- Not defined: every valid port is enqueued, duplicates included, in port order.

## Structure
- Package difftest_vecwb_pkg:
  - typedef vecwb_entry_t {addr[6:0], data[127:0], coreid[7:0]}.
  - VLEN = 128 and ADDR_W = 7 constants.
  - A saturating-add function for drop_cnt.
- Sub-module difftest_vecwb_fifo: a multi-push, single-pop circular buffer. It takes a compacted push vector and a push count, and returns the accepted count.
- Port compaction, the optional dedup logic and the output register stage stay in the top module.

## Test plan
- Single push, empty queue: port 0 writes addr 5, data 0x1111…_2222… → next cycle out_enable = 1, out_address = 5, out_data_1 = 0x1111…, out_data_0 = 0x2222…; following cycle out_enable = 0.
- All ports valid with addresses 1, 2, 3, 4 → events emitted in 4 consecutive cycles with addresses 1, 2, 3, 4; stall stays low.
- Fill to 13 entries with NPORTS = 4 and no pop → stall = 1. Then push 4 with a concurrent pop → all 4 accepted and overflow stays 0.
- Full queue and 4 valid pushes with a pop → 1 accepted, 3 dropped; overflow = 1 and drop_cnt = 3, then sticky until reset.
- Ports 0 and 2 both write addr 9 with data A and B → with DEDUP_EN, one event carrying data B; without it, two events A then B.
- Assert reset with 10 entries queued → the next cycle has out_enable = 0, count = 0, overflow = 0 and drop_cnt = 0, and a fresh push then appears 1 cycle later.
